// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and defaults for the serializer and its downstream detector
package seq_pkg;

  // Serializer FSM: IDLE = shifter empty, SHIFT = shifter holds a word.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  // State encodings of the downstream sequence detector.
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } det_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock word FIFO with registered count
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset
//   push, wdata     : write request and data (ignored when full)
//   pop, rdata      : read request (ignored when empty); rdata shows the head word
//   full, empty     : flags decoded from the registered count
//   count           : number of stored words, clog2(DEPTH)+1 bits
module sync_fifo
  import seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers are exactly PTR_W bits wide, so +1 wraps modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - buffers parallel words and shifts them out one bit per cycle
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   in_data, in_valid  : parallel word input, accepted when in_valid & in_ready
//   in_ready           : FIFO has room (from registered count)
//   x, x_valid         : serial bit and its qualifier
//   busy               : FIFO non-empty or shifter active
module word_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy
);

  localparam int                 CNT_W    = $clog2(WIDTH);
  localparam int                 FCNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);

  ser_state_e        state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

  logic              fifo_push, fifo_pop;
  logic              fifo_full, fifo_empty;
  logic [WIDTH-1:0]  fifo_rdata;
  logic [FCNT_W-1:0] fifo_count;
  logic              last_bit;
  logic              head_bit;

  assign in_ready  = ~fifo_full;
  assign fifo_push = in_valid & in_ready;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wdata   (in_data),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // The pop decision uses only registered state, so a word written into an
  // empty FIFO is not visible to the shifter until the following edge.
  assign last_bit = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);
  assign fifo_pop = ~fifo_empty && ((state_q == IDLE) || last_bit);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (fifo_pop) begin
      // Reload straight after the last bit keeps words back-to-back.
      state_d   = SHIFT;
      shreg_d   = fifo_rdata;
      bit_cnt_d = '0;
    end else if (state_q == SHIFT) begin
      if (last_bit) begin
        state_d   = IDLE;
        shreg_d   = '0;
        bit_cnt_d = '0;
      end else begin
        shreg_d   = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg_q[WIDTH-1:1]};
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign head_bit = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
  assign x_valid  = (state_q == SHIFT);
  assign x        = x_valid & head_bit;
  assign busy     = (fifo_count != '0) || (state_q == SHIFT);

endmodule

// File: tb/tb_word_serializer.sv
// tb/tb_word_serializer.sv - self-checking bench for word_serializer (MSB- and LSB-first instances)
module tb_word_serializer;
  import seq_pkg::*;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         ready_m, x_m, xv_m, busy_m;
  logic         ready_l, x_l, xv_l, busy_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  word_serializer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ready_m), .x(x_m), .x_valid(xv_m), .busy(busy_m)
  );

  word_serializer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ready_l), .x(x_l), .x_valid(xv_l), .busy(busy_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queued words plus the word currently on the wire and
  // the index of the bit being shown (-1 when nothing is being sent).
  logic [W-1:0] mq[$];
  logic [W-1:0] cur;
  int           pos = -1;

  task automatic model_reset();
    mq.delete();
    cur = '0;
    pos = -1;
  endtask

  function automatic logic model_x(input bit msb);
    if (pos < 0) return 1'b0;
    return msb ? cur[W-1-pos] : cur[pos];
  endfunction

  task automatic check_model();
    chk("ready_msb", 32'(ready_m), 32'(mq.size() < D));
    chk("ready_lsb", 32'(ready_l), 32'(mq.size() < D));
    chk("xv_msb",    32'(xv_m),    32'(pos >= 0));
    chk("xv_lsb",    32'(xv_l),    32'(pos >= 0));
    chk("x_msb",     32'(x_m),     32'(model_x(1'b1)));
    chk("x_lsb",     32'(x_l),     32'(model_x(1'b0)));
    chk("busy_msb",  32'(busy_m),  32'((mq.size() > 0) || (pos >= 0)));
    chk("busy_lsb",  32'(busy_l),  32'((mq.size() > 0) || (pos >= 0)));
  endtask

  // One clock: check outputs against the model, apply inputs, advance the
  // model across the rising edge, return at the following falling edge.
  task automatic cycle(input logic v, input logic [W-1:0] d);
    bit acc;
    in_valid = v;
    in_data  = d;
    check_model();
    acc = v && (mq.size() < D);
    @(posedge clk);
    if (pos < 0 || pos == W - 1) begin
      if (mq.size() > 0) begin
        cur = mq.pop_front();
        pos = 0;
      end else begin
        pos = -1;
      end
    end else begin
      pos++;
    end
    if (acc) mq.push_back(d);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(ready_m & ready_l), 32'd1);
    chk({tag, "_x"},     32'(x_m | x_l),         32'd0);
    chk({tag, "_xv"},    32'(xv_m | xv_l),       32'd0);
    chk({tag, "_busy"},  32'(busy_m | busy_l),   32'd0);
  endtask

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         x_m;
    logic         x_l;
    logic         xv;
    logic         ready;
    logic         busy;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(logic v, logic [W-1:0] d, logic xm, logic xl,
                              logic xv, logic rdy, logic bsy);
    vec_t r;
    r.v = v; r.d = d; r.x_m = xm; r.x_l = xl; r.xv = xv; r.ready = rdy; r.busy = bsy;
    return r;
  endfunction

  initial begin
    logic [15:0] got16;
    logic [7:0]  got8;
    int          nv;
    bit          gap;
    int          acc_cnt;
    int          zeros;
    int          xv_cnt;
    logic [7:0]  cc_pat;

    // Single word 8'hCC pushed into an idle block: one idle cycle of
    // latency, eight bits, then idle again.
    cc_pat  = 8'hCC;
    vecs[0] = mk(1'b1, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[1] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++)
      vecs[2+i] = mk(1'b0, 8'h00, cc_pat[7-i], cc_pat[i], 1'b1, 1'b1, 1'b1);
    vecs[10] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset held with in_valid asserted: nothing may be accepted.
    reset_n  = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset_outputs("in_reset");
    end
    reset_n  = 1'b1;
    in_valid = 1'b0;
    cycle(1'b0, 8'h00);
    check_reset_outputs("post_reset");

    // Table-driven single word.
    foreach (vecs[i]) begin
      chk("tbl_x_msb", 32'(x_m),     32'(vecs[i].x_m));
      chk("tbl_x_lsb", 32'(x_l),     32'(vecs[i].x_l));
      chk("tbl_xv",    32'(xv_m),    32'(vecs[i].xv));
      chk("tbl_ready", 32'(ready_m), 32'(vecs[i].ready));
      chk("tbl_busy",  32'(busy_m),  32'(vecs[i].busy));
      cycle(vecs[i].v, vecs[i].d);
    end

    // Back-to-back words stream with no gap.
    cycle(1'b1, 8'hF0);
    cycle(1'b1, 8'h0C);
    got16 = '0;
    nv    = 0;
    gap   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (xv_m) begin
        if (nv < 16) got16 = {got16[14:0], x_m};
        nv++;
      end else if (nv > 0 && nv < 16) begin
        gap = 1'b1;
      end
      cycle(1'b0, 8'h00);
    end
    chk("b2b_bits", 32'(got16), 32'h0000_F00C);
    chk("b2b_count", 32'(nv), 32'd16);
    chk("b2b_gap", 32'(gap), 32'd0);

    // Full FIFO: capacity is DEPTH words plus one in the shifter.
    acc_cnt = 0;
    for (int i = 0; i < 20 && ready_m; i++) begin
      acc_cnt++;
      cycle(1'b1, W'($urandom));
    end
    chk("full_accepts", 32'(acc_cnt), 32'(D + 1));
    zeros = 0;
    for (int i = 0; i < 20 && !ready_m; i++) begin
      zeros++;
      cycle(1'b1, W'($urandom));
    end
    chk("full_stall_cycles", 32'(zeros), 32'(W - 3));
    for (int i = 0; i < 60; i++) cycle(1'b0, 8'h00);
    chk("full_drained", 32'(busy_m), 32'd0);

    // 8'h01 on both bit orders.
    cycle(1'b1, 8'h01);
    cycle(1'b0, 8'h00);
    got8 = '0;
    got16 = '0;
    for (int i = 0; i < 8; i++) begin
      chk("one_xv_lsb", 32'(xv_l), 32'd1);
      got8  = {got8[6:0], x_l};
      got16 = {got16[14:0], x_m};
      cycle(1'b0, 8'h00);
    end
    chk("one_lsb_bits", 32'(got8), 32'h80);
    chk("one_msb_bits", 32'(got16[7:0]), 32'h01);
    chk("one_idle_after", 32'(xv_l), 32'd0);

    // Reset in the middle of 8'hAA with two words queued.
    cycle(1'b1, 8'hAA);
    cycle(1'b1, 8'h11);
    cycle(1'b1, 8'h22);
    cycle(1'b0, 8'h00);
    chk("mid_before_xv", 32'(xv_m), 32'd1);
    chk("mid_queued", 32'(mq.size()), 32'd2);
    reset_n  = 1'b0;
    in_valid = 1'b1;
    #1;
    check_reset_outputs("mid_async");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid_held");
    reset_n = 1'b1;
    xv_cnt  = 0;
    for (int i = 0; i < 12; i++) begin
      if (xv_m) xv_cnt++;
      cycle(1'b0, 8'h00);
    end
    chk("mid_no_stale_bits", 32'(xv_cnt), 32'd0);
    cycle(1'b1, 8'h5A);
    got8 = '0;
    for (int i = 0; i < 12; i++) begin
      if (xv_m) begin
        xv_cnt++;
        got8 = {got8[6:0], x_m};
      end
      cycle(1'b0, 8'h00);
    end
    chk("mid_new_count", 32'(xv_cnt), 32'd8);
    chk("mid_new_word", 32'(got8), 32'h5A);

    // Random traffic at several offered loads.
    for (int blk = 0; blk < 4; blk++) begin
      int pct;
      pct = (blk == 0) ? 10 : (blk == 1) ? 40 : (blk == 2) ? 90 : 100;
      for (int i = 0; i < 150; i++)
        cycle(($urandom_range(0, 99) < pct), W'($urandom));
    end
    for (int i = 0; i < 60; i++) cycle(1'b0, 8'h00);
    chk("final_idle", 32'(busy_m | busy_l), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
